// File: rtl/serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module      : serial_to_parallel
// Description : I2S receiver; deserialises MSB-first left/right words into
//               pairs with a valid/ready hand-off. Optional macro
//               RX_OVERFLOW_COUNT_EN adds a saturating dropped-pair counter.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_to_parallel #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_bit_clk,
    input  logic                  i_reset_n,
    input  logic                  i_serial_data,
    input  logic                  i_lr_clk,
    output logic [DATA_WIDTH-1:0] o_left_data,
    output logic [DATA_WIDTH-1:0] o_right_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_overflow,
    output logic                  o_frame_err,
    output logic [15:0]           o_overflow_count
);

    localparam int                 c_CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_lr_d;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_left_word;
    logic [DATA_WIDTH-1:0] r_right_word;
    logic                  r_left_ok;
    logic                  r_pair_done;
    logic                  r_frame_err;
    logic                  r_valid;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_left_out;
    logic [DATA_WIDTH-1:0] r_right_out;

    logic                  w_edge;
    logic                  w_fall;
    logic                  w_rise;
    logic                  w_sample;
    logic                  w_last;
    logic                  w_trunc;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_edge       = i_lr_clk ^ r_lr_d;
    assign w_fall       = w_edge & ~i_lr_clk;
    assign w_rise       = w_edge & i_lr_clk;
    // The edge cycle itself carries no data bit; the count saturates at DATA_WIDTH.
    assign w_sample     = (r_state != SYNC) && !w_edge && (r_bit_cnt != c_CNT_MAX);
    assign w_last       = w_sample && (r_bit_cnt == (c_CNT_MAX - 1'b1));
    assign w_trunc      = w_edge && (r_state != SYNC) && (r_bit_cnt != '0) && (r_bit_cnt != c_CNT_MAX);
    assign w_shift_next = {r_shift[DATA_WIDTH-2:0], i_serial_data};
    assign w_drop       = r_pair_done && r_valid && !i_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SYNC:    if (w_fall) w_state_next = LEFT;
            LEFT:    if (w_rise) w_state_next = RIGHT;
            RIGHT:   if (w_fall) w_state_next = LEFT;
            default: w_state_next = SYNC;
        endcase
    end

    always_ff @(posedge i_bit_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= SYNC;
            r_lr_d       <= 1'b0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_left_word  <= '0;
            r_right_word <= '0;
            r_left_ok    <= 1'b0;
            r_pair_done  <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lr_d      <= i_lr_clk;
            r_frame_err <= w_trunc;
            r_pair_done <= w_last && (r_state == RIGHT) && r_left_ok;

            if (w_edge)
                r_bit_cnt <= '0;
            else if (w_sample)
                r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_sample)
                r_shift <= w_shift_next;

            // A left word is only good for the frame it starts.
            if (w_fall || (w_trunc && (r_state == LEFT))) begin
                r_left_ok <= 1'b0;
            end else if (w_last && (r_state == LEFT)) begin
                r_left_word <= w_shift_next;
                r_left_ok   <= 1'b1;
            end

            if (w_last && (r_state == RIGHT) && r_left_ok)
                r_right_word <= w_shift_next;
        end
    end

    always_ff @(posedge i_bit_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_left_out  <= '0;
            r_right_out <= '0;
        end else begin
            r_overflow <= w_drop;
            if (r_pair_done && (!r_valid || i_ready)) begin
                r_valid     <= 1'b1;
                r_left_out  <= r_left_word;
                r_right_out <= r_right_word;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef RX_OVERFLOW_COUNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge i_bit_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_ovf_cnt <= 16'h0000;
        else if (w_drop && (r_ovf_cnt != 16'hFFFF))
            r_ovf_cnt <= r_ovf_cnt + 16'h0001;
    end

    assign o_overflow_count = r_ovf_cnt;
`else
    assign o_overflow_count = 16'h0000;
`endif

    assign o_left_data  = r_left_out;
    assign o_right_data = r_right_out;
    assign o_valid      = r_valid;
    assign o_overflow   = r_overflow;
    assign o_frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_to_parallel
// Description : Self-checking bench for serial_to_parallel (table rows plus
//               hand-written corner sequences, scoreboard on output pairs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel;

    localparam int DW = 32;
`ifdef RX_OVERFLOW_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ser   = 1'b0;
    logic          lr    = 1'b0;
    logic          ready = 1'b0;
    logic [DW-1:0] left_d;
    logic [DW-1:0] right_d;
    logic          valid;
    logic          ovf;
    logic          ferr;
    logic [15:0]   ovf_cnt;

    always #5 clk = ~clk;

    serial_to_parallel #(.DATA_WIDTH(DW)) dut (
        .i_bit_clk        (clk),
        .i_reset_n        (rst_n),
        .i_serial_data    (ser),
        .i_lr_clk         (lr),
        .o_left_data      (left_d),
        .o_right_data     (right_d),
        .o_valid          (valid),
        .i_ready          (ready),
        .o_overflow       (ovf),
        .o_frame_err      (ferr),
        .o_overflow_count (ovf_cnt)
    );

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            nl;
        int            nr;
        bit            rdy;
        bit            push;
        int            ferr;
        int            ovf;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] exp_q[$];
    int          n_tests     = 0;
    int          n_fail      = 0;
    int          ferr_seen   = 0;
    int          ovf_seen    = 0;
    int          exp_ovf_cnt = 0;
    bit          held        = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chan(input logic side, input logic [DW-1:0] word, input int nbits);
        lr = side;
        tick();
        for (int i = 0; i < nbits; i++) begin
            ser = (i < DW) ? word[DW-1-i] : 1'b1;
            tick();
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nl, input int nr);
        send_chan(1'b0, l, nl);
        send_chan(1'b1, r, nr);
    endtask

    task automatic garbage(input int n);
        for (int i = 0; i < n; i++) begin
            ser = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    initial begin
        int f0;
        int o0;

        vecs[0] = '{32'hA5A50001, 32'h5A5A8002, 32, 32, 1'b1, 1'b1, 0, 0};
        vecs[1] = '{32'hDEADBEEF, 32'h01234567, 20, 32, 1'b1, 1'b0, 1, 0};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 32, 32, 1'b1, 1'b1, 0, 0};
        vecs[3] = '{32'h0F0F0F0E, 32'h80000000, 36, 36, 1'b1, 1'b1, 0, 0};
        vecs[4] = '{$urandom,     $urandom,     32, 32, 1'b1, 1'b1, 0, 0};
        vecs[5] = '{32'hCAFEF00D, 32'h13579BDF, 32, 32, 1'b0, 1'b1, 0, 0};
        vecs[6] = '{32'h55AA33CC, 32'hFFFF0000, 32, 32, 1'b0, 1'b0, 0, 1};
        vecs[7] = '{32'h00000001, 32'h80000001, 32, 32, 1'b1, 1'b1, 0, 0};

        fork
            begin : monitor
                logic        prev_valid  = 1'b0;
                logic        prev_accept = 1'b0;
                logic [63:0] held_data   = '0;
                forever begin
                    @(negedge clk);
                    if (ferr) ferr_seen++;
                    if (ovf)  ovf_seen++;
                    if (valid && (!prev_valid || prev_accept)) begin
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_pair: got %h expected none", {left_d, right_d});
                        end else begin
                            check("pair_data", {left_d, right_d}, exp_q.pop_front());
                        end
                    end else if (valid && prev_valid) begin
                        check("pair_hold", {left_d, right_d}, held_data);
                    end
                    held_data   = {left_d, right_d};
                    prev_valid  = valid;
                    prev_accept = valid && ready;
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_valid",     64'(valid),   64'h0);
        check("rst_left",      64'(left_d),  64'h0);
        check("rst_right",     64'(right_d), 64'h0);
        check("rst_overflow",  64'(ovf),     64'h0);
        check("rst_frame_err", 64'(ferr),    64'h0);
        check("rst_ovf_count", 64'(ovf_cnt), 64'h0);

        // Released with word select high: nothing may be captured before a falling edge
        rst_n = 1'b1;
        lr    = 1'b1;
        garbage(40);
        check("sync_no_valid", 64'(valid), 64'h0);

        for (int k = 0; k < 8; k++) begin
            bit timed;
            timed = (vecs[k].nr == DW);
            ready = vecs[k].rdy;
            if (vecs[k].rdy) held = 1'b0;
            f0 = ferr_seen;
            o0 = ovf_seen;
            if (vecs[k].push) exp_q.push_back({vecs[k].l, vecs[k].r});
            send_frame(vecs[k].l, vecs[k].r, vecs[k].nl, vecs[k].nr);
            if (timed) check($sformatf("row%0d_valid_pre", k), 64'(valid), 64'(held));
            tick();
            if (timed) check($sformatf("row%0d_valid_post", k), 64'(valid), 64'(held || vecs[k].push));
            tick();
            tick();
            if (!vecs[k].rdy && (vecs[k].push || held)) held = 1'b1;
            if (CNT_EN) exp_ovf_cnt += vecs[k].ovf;
            check($sformatf("row%0d_frame_err", k), 64'(ferr_seen - f0), 64'(vecs[k].ferr));
            check($sformatf("row%0d_overflow", k),  64'(ovf_seen - o0),  64'(vecs[k].ovf));
            check($sformatf("row%0d_ovf_count", k), 64'(ovf_cnt),        64'(exp_ovf_cnt));
        end
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        // New pair completes on the very cycle the held pair is accepted
        ready = 1'b0;
        o0    = ovf_seen;
        exp_q.push_back({32'h11112222, 32'h33334444});
        send_frame(32'h11112222, 32'h33334444, 32, 32);
        tick();
        tick();
        exp_q.push_back({32'h55556666, 32'h77778888});
        send_frame(32'h55556666, 32'h77778888, 32, 32);
        ready = 1'b1;
        tick();
        check("accept_load_valid", 64'(valid), 64'h1);
        check("accept_load_data",  {left_d, right_d}, {32'h55556666, 32'h77778888});
        tick();
        check("accept_load_done",  64'(valid), 64'h0);
        tick();
        check("accept_load_no_ovf", 64'(ovf_seen - o0), 64'h0);
        check("accept_queue",       64'(exp_q.size()),  64'h0);

        // Asynchronous reset in the middle of a right word, with a pair held
        ready = 1'b0;
        exp_q.push_back({32'hFEDCBA98, 32'h76543210});
        send_frame(32'hFEDCBA98, 32'h76543210, 32, 32);
        tick();
        tick();
        send_chan(1'b0, 32'h0BADCAFE, 32);
        send_chan(1'b1, 32'hFFFFFFFF, 10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid",     64'(valid),   64'h0);
        check("arst_left",      64'(left_d),  64'h0);
        check("arst_right",     64'(right_d), 64'h0);
        check("arst_ovf_count", 64'(ovf_cnt), 64'h0);
        check("arst_queue",     64'(exp_q.size()), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        garbage(40);
        check("arst_sync_no_valid", 64'(valid), 64'h0);
        exp_q.push_back({32'h2468ACE0, 32'h13579BDF});
        send_frame(32'h2468ACE0, 32'h13579BDF, 32, 32);
        repeat (3) tick();
        check("final_queue",     64'(exp_q.size()), 64'h0);
        check("final_frame_err", 64'(ferr_seen),    64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving bits per channel word.
REQ-002 SHALL have port i_bit_clk  input  1  the single clock; all logic on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_serial_data  input  1  I2S serial data, MSB first.
REQ-005 SHALL have port i_lr_clk  input  1  word select: 0 = left channel, 1 = right channel.
REQ-006 SHALL have port o_left_data  output  DATA_WIDTH  captured left word.
REQ-007 SHALL have port o_right_data  output  DATA_WIDTH  captured right word.
REQ-008 SHALL have port o_valid  output  1  pair available.
REQ-009 SHALL have port i_ready  input  1  sink accepts pair.
REQ-010 SHALL have port o_overflow  output  1  one-cycle pulse when a completed pair is dropped.
REQ-011 SHALL have port o_frame_err  output  1  one-cycle pulse when a channel word is truncated.
REQ-012 SHALL have port o_overflow_count  output  16  count of dropped pairs.

Function
REQ-013 SHALL register i_lr_clk into lr_d each cycle; "edge cycle" = cycle where i_lr_clk != lr_d.
REQ-014 SHALL implement states SYNC, LEFT, RIGHT; SYNC->LEFT on falling edge, LEFT->RIGHT on rising edge, RIGHT->LEFT on falling edge; SYNC ignores rising edges.
REQ-015 SHALL clear the bit counter on each edge cycle and sample i_serial_data on the next DATA_WIDTH rising edges, shifting MSB first.
REQ-016 SHALL ignore bits after the DATA_WIDTH-th until the next edge cycle.
REQ-017 SHALL, on an edge cycle with bit count of the current channel between 1 and DATA_WIDTH-1, pulse o_frame_err and mark that channel word invalid.
REQ-018 SHALL complete a pair when the DATA_WIDTH-th right bit is sampled and the left word of the same frame is valid; otherwise discard the right word.
REQ-019 SHALL assert o_valid and update o_left_data/o_right_data one clock after the completing sample.
REQ-020 SHALL hold o_valid and data stable until a cycle with o_valid and i_ready both high; o_valid deasserts the next clock.
REQ-021 SHALL, when a pair completes while o_valid=1 and i_ready=0, drop the new pair, keep held data, and pulse o_overflow.
REQ-022 SHALL, when a pair completes in the same cycle that i_ready accepts the held pair, load the new pair with o_valid staying 1 and no overflow.

Reset
REQ-023 SHALL, on i_reset_n low, immediately clear all outputs, counters, lr_d and shift registers, and enter SYNC.
REQ-024 SHALL produce no o_valid after reset release until a falling edge plus one complete frame.

Configuration
REQ-025 SHALL, with RX_OVERFLOW_COUNT_EN defined, increment o_overflow_count on each o_overflow pulse, saturating at 0xFFFF, cleared only by reset.
REQ-026 SHALL, without RX_OVERFLOW_COUNT_EN, tie o_overflow_count to 0 and omit the counter logic.

Verification
REQ-027 Reset, falling edge, L=0xA5A50001, R=0x5A5A8002, i_ready=1 -> o_valid for 1 cycle one clock after the 32nd right bit, data matching exactly.
REQ-028 i_ready=0 over two full frames -> first pair held unchanged, o_overflow pulses once, o_overflow_count=1 with macro (0 without).
REQ-029 Rising LR edge after 20 left bits -> o_frame_err pulses once, no o_valid that frame, next complete frame L=0x12345678/R=0x9ABCDEF0 is output.
REQ-030 i_reset_n low mid-right-word -> all outputs 0 asynchronously; after release with i_lr_clk=1, no capture until a falling edge.
REQ-031 Pair completes on the cycle i_ready accepts the held pair -> o_valid stays high, new data loaded, o_overflow stays 0.
REQ-032 36 bit clocks per channel with trailing bits 1 -> extra bits ignored, words equal to the first 32 bits sent.
